// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin, packet-locked arbiter sharing the single write port of a BRAM
// FIFO among NUM requester streams. A requester keeps the grant from its first
// beat until its `last` beat has been written. Each FIFO word carries the
// requester's last flag above the payload: {last, data}.
//
// Optional feature (compile-time macro FIFO_ARB_TIMEOUT_EN):
//   When defined, a lock whose owner withholds in_valid for TIMEOUT
//   non-full cycles is force-released and timeout_err pulses for one cycle.
//   When undefined, the lock is held until `last` and timeout_err is tied 0.
module fifo_wr_arbiter #(
    parameter int NUM     = 4,
    parameter int DSIZE   = 35,
    parameter int TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [NUM-1:0]          in_valid,
    input  logic [NUM-1:0]          in_last,
    input  logic [NUM*DSIZE-1:0]    in_data,
    output logic [NUM-1:0]          in_ready,
    output logic [DSIZE:0]          fifo_din,
    output logic                    fifo_wr_en,
    input  logic                    fifo_full,
    output logic [$clog2(NUM)-1:0]  grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NUM);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t            state_r;
    logic [IW-1:0]     grant_id_r;
    logic [IW-1:0]     rr_ptr_r;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_found_s;
    logic              sel_valid_s;
    logic              sel_last_s;
    logic [DSIZE-1:0]  sel_data_s;
    logic [NUM-1:0]    in_ready_s;
    logic              xfer_s;

    // Out-of-range configurations are rejected when the design is elaborated.
    if (NUM < 2 || NUM > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("fifo_wr_arbiter: NUM must be 2..8 and TIMEOUT >= 2");
    end

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     stall_cnt_r;
    logic              timeout_err_r;
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    // Round-robin search: first valid requester after rr_ptr, wrapping modulo NUM.
    always_comb begin
        logic [IW-1:0] cand;
        pick_found_s = 1'b0;
        pick_idx_s   = rr_ptr_r;
        cand         = rr_ptr_r;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = NUM; k >= 1; k--) begin
            cand = IW'((int'(rr_ptr_r) + k) % NUM);
            if (in_valid[cand]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand;
            end else begin
                cand = cand;
            end
        end
    end

    // Select the granted requester's valid/last/data lanes.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        for (int i = 0; i < NUM; i++) begin
            if (grant_id_r == IW'(i)) begin
                sel_valid_s = in_valid[i];
                sel_last_s  = in_last[i];
                sel_data_s  = in_data[i*DSIZE +: DSIZE];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Only the lock owner sees ready, and only while the FIFO has room.
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < NUM; i++) begin
            if ((state_r == ST_LOCK) && (grant_id_r == IW'(i))) begin
                in_ready_s[i] = ~fifo_full;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    assign xfer_s     = (state_r == ST_LOCK) & sel_valid_s & ~fifo_full;
    assign in_ready   = in_ready_s;
    assign fifo_wr_en = xfer_s;
    assign fifo_din   = {sel_last_s, sel_data_s};
    assign grant_id   = grant_id_r;
    assign busy       = (state_r == ST_LOCK);

    // Arbitration FSM: IDLE picks a winner, LOCK holds it until the last beat.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= IW'(NUM - 1);
`ifdef FIFO_ARB_TIMEOUT_EN
            stall_cnt_r   <= '0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
`ifdef FIFO_ARB_TIMEOUT_EN
            timeout_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
`ifdef FIFO_ARB_TIMEOUT_EN
                    stall_cnt_r <= '0;
`endif
                    if (pick_found_s) begin
                        state_r    <= ST_LOCK;
                        grant_id_r <= pick_idx_s;
                        rr_ptr_r   <= pick_idx_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (xfer_s && sel_last_s) begin
                        state_r <= ST_IDLE;
`ifdef FIFO_ARB_TIMEOUT_EN
                        stall_cnt_r <= '0;
                    end else if (sel_valid_s) begin
                        stall_cnt_r <= '0;
                    end else if (fifo_full) begin
                        // A full FIFO is not the requester's fault; freeze the timer.
                        stall_cnt_r <= stall_cnt_r;
                    end else if (stall_cnt_r == CW'(TIMEOUT - 1)) begin
                        state_r       <= ST_IDLE;
                        timeout_err_r <= 1'b1;
                        stall_cnt_r   <= '0;
                    end else begin
                        stall_cnt_r <= stall_cnt_r + CW'(1);
                    end
`else
                    end else begin
                        state_r <= ST_LOCK;
                    end
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a packet-level reference model
// predicts every output each cycle, and directed scenarios pin literal
// expectations (grant order, write timing, stall and reset behaviour).
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NUM     = 4;
    localparam int DSIZE   = 35;
    localparam int TIMEOUT = 8;
    localparam int IW      = 2;

    logic                   clock = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NUM-1:0]         in_valid;
    logic [NUM-1:0]         in_last;
    logic [NUM*DSIZE-1:0]   in_data;
    logic [NUM-1:0]         in_ready;
    logic [DSIZE:0]         fifo_din;
    logic                   fifo_wr_en;
    logic                   fifo_full;
    logic [IW-1:0]          grant_id;
    logic                   busy;
    logic                   timeout_err;

    fifo_wr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .rst_n(rst_n),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(in_ready), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requester sources
    int pkts_left[NUM];
    int pkt_len[NUM];
    int beat[NUM];
    int pkt_no[NUM];
    bit hold[NUM];
    bit fire[NUM];

    // Observed FIFO write log
    int wr_cyc[$];
    int wr_port[$];
    int wr_last[$];
    int wr_beat[$];
    int wr_total = 0;
    int err_seen = 0;
    int err_cyc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        logic [DSIZE-1:0] d;
        for (int i = 0; i < NUM; i++) begin
            d = '0;
            d[7:0]   = beat[i][7:0];
            d[15:8]  = pkt_no[i][7:0];
            d[19:16] = i[3:0];
            d[DSIZE-1] = i[0];
            in_valid[i] = (pkts_left[i] > 0) && !hold[i];
            in_last[i]  = (beat[i] == pkt_len[i] - 1);
            in_data[i*DSIZE +: DSIZE] = d;
        end
    endtask

    task automatic start_pkt(input int p, input int n, input int len);
        pkts_left[p] = n;
        pkt_len[p]   = len;
        beat[p]      = 0;
        drive();
    endtask

    // One clock: note handshakes at negedge, advance sources just after posedge.
    task automatic step();
        @(negedge clock);
        for (int i = 0; i < NUM; i++) fire[i] = in_valid[i] & in_ready[i];
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (fire[i]) begin
                if (beat[i] == pkt_len[i] - 1) begin
                    beat[i] = 0;
                    pkt_no[i]++;
                    pkts_left[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic wait_writes(input string name, input int target, input int budget);
        int n = 0;
        while (wr_total < target && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(wr_total >= target), 64'd1);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        bit pend = 1'b1;
        while (pend && n < budget) begin
            step();
            n++;
            pend = (busy === 1'b1);
            for (int i = 0; i < NUM; i++) if (pkts_left[i] > 0) pend = 1'b1;
        end
        check(name, 64'(pend), 64'd0);
    endtask

    // Reference model: packet-level arbiter, checked against DUT every cycle.
    initial begin
        bit  m_lock;
        int  m_g, m_last, m_cnt;
        bit  m_err;
        logic [NUM-1:0] e_ready;
        bit  e_wr;
        m_lock = 0; m_g = 0; m_last = NUM - 1; m_cnt = 0; m_err = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!rst_n) begin
                m_lock = 0; m_g = 0; m_last = NUM - 1; m_cnt = 0; m_err = 0;
            end
            e_ready = '0;
            e_wr    = 1'b0;
            if (m_lock) begin
                e_ready[m_g] = !fifo_full;
                e_wr = in_valid[m_g] && !fifo_full;
            end
            check("busy", 64'(busy), 64'(m_lock));
            check("grant_id", 64'(grant_id), 64'(m_g));
            check("in_ready", 64'(in_ready), 64'(e_ready));
            check("fifo_wr_en", 64'(fifo_wr_en), 64'(e_wr));
            check("timeout_err", 64'(timeout_err), 64'(m_err));
            if (e_wr) check("fifo_din", 64'(fifo_din), 64'({in_last[m_g], in_data[m_g*DSIZE +: DSIZE]}));
            if (fifo_wr_en === 1'b1) begin
                wr_cyc.push_back(cyc);
                wr_port.push_back(int'(grant_id));
                wr_last.push_back(int'(fifo_din[DSIZE]));
                wr_beat.push_back(int'(fifo_din[7:0]));
                wr_total++;
            end
            if (timeout_err === 1'b1) begin
                err_seen++;
                err_cyc = cyc;
            end
            if (rst_n) begin
                m_err = 1'b0;
                if (!m_lock) begin
                    for (int k = 1; k <= NUM; k++) begin
                        if (in_valid[(m_last + k) % NUM]) begin
                            m_lock = 1; m_g = (m_last + k) % NUM; m_last = m_g; m_cnt = 0;
                            break;
                        end
                    end
                end else if (e_wr && in_last[m_g]) begin
                    m_lock = 0;
                end
`ifdef FIFO_ARB_TIMEOUT_EN
                else if (in_valid[m_g]) m_cnt = 0;
                else if (!fifo_full) begin
                    m_cnt++;
                    if (m_cnt >= TIMEOUT) begin m_lock = 0; m_err = 1; m_cnt = 0; end
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c0, rb, e0;
        int ord[5];
        ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NUM; i++) begin
            pkts_left[i] = 0; pkt_len[i] = 0; beat[i] = 0; pkt_no[i] = 0; hold[i] = 0; fire[i] = 0;
        end
        fifo_full = 1'b0;
        drive();
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_terr", 64'(timeout_err), 64'd0);
        step(); step();
        rst_n = 1'b1;

        // Test 1: single 3-beat packet on port 0
        c0 = cyc;
        base = wr_total;
        start_pkt(0, 1, 3);
        wait_writes("t1_wait", base + 3, 20);
        for (int i = 0; i < 3; i++) begin
            check("t1_cyc", 64'(wr_cyc[base+i]), 64'(c0 + 2 + i));
            check("t1_port", 64'(wr_port[base+i]), 64'd0);
            check("t1_last", 64'(wr_last[base+i]), 64'(i == 2));
        end
        check("t1_busy_after", 64'(busy), 64'd0);

        // Test 2: all ports, two 2-beat packets each, fresh from reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        base = wr_total;
        for (int p = 0; p < NUM; p++) start_pkt(p, 2, 2);
        wait_writes("t2_wait", base + 16, 80);
        for (int k = 0; k < 5; k++) begin
            check("t2_order", 64'(wr_port[base+2*k]), 64'(ord[k]));
            check("t2_last0", 64'(wr_last[base+2*k]), 64'd0);
            check("t2_last1", 64'(wr_last[base+2*k+1]), 64'd1);
        end
        check("t2_bubble", 64'(wr_cyc[base+2] - wr_cyc[base+1]), 64'd2);
        check("t2_span", 64'(wr_cyc[base+8] - wr_cyc[base]), 64'd12);

        // Test 3: port 2 stalled by fifo_full for 5 cycles mid-packet
        base = wr_total;
        start_pkt(2, 1, 6);
        wait_writes("t3_wait_a", base + 2, 20);
        fifo_full = 1'b1;
        repeat (5) step();
        check("t3_no_write", 64'(wr_total), 64'(base + 2));
        check("t3_ready", 64'(in_ready), 64'd0);
        check("t3_grant", 64'(grant_id), 64'd2);
        check("t3_busy", 64'(busy), 64'd1);
        fifo_full = 1'b0;
        wait_writes("t3_wait_b", base + 6, 20);
        check("t3_resume", 64'(wr_cyc[base+2] - wr_cyc[base+1]), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check("t3_beat", 64'(wr_beat[base+i]), 64'(i));
            check("t3_port", 64'(wr_port[base+i]), 64'd2);
        end

        // Test 4: port 3 arrives while port 1 is locked; single-beat packet
        base = wr_total;
        start_pkt(1, 1, 4);
        wait_writes("t4_wait_a", base + 1, 20);
        start_pkt(3, 1, 1);
        wait_writes("t4_wait_b", base + 5, 30);
        for (int i = 0; i < 4; i++) check("t4_port1", 64'(wr_port[base+i]), 64'd1);
        check("t4_port3", 64'(wr_port[base+4]), 64'd3);
        check("t4_gap", 64'(wr_cyc[base+4] - wr_cyc[base+3]), 64'd2);
        check("t4_single_last", 64'(wr_last[base+4]), 64'd1);
        check("t4_idle", 64'(busy), 64'd0);

        // Test 5: async reset while port 2 holds the lock
        base = wr_total;
        start_pkt(2, 1, 10);
        wait_writes("t5_wait", base + 2, 20);
        start_pkt(0, 1, 2);
        start_pkt(1, 1, 2);
        start_pkt(3, 1, 2);
        step();
        check("t5_pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_ready", 64'(in_ready), 64'd0);
        check("t5_async_wr", 64'(fifo_wr_en), 64'd0);
        step(); step();
        rst_n = 1'b1;
        rb = wr_total;
        wait_writes("t5_wait_post", rb + 1, 10);
        check("t5_winner", 64'(wr_port[rb]), 64'd0);
        drain("t5_drain", 200);

        // Test 6: lock owner drops valid mid-packet while port 1 waits
        base = wr_total;
        start_pkt(0, 1, 4);
        wait_writes("t6_wait_a", base + 2, 20);
        hold[0] = 1'b1;
        start_pkt(1, 1, 1);
        e0 = err_seen;
`ifdef FIFO_ARB_TIMEOUT_EN
        repeat (12) step();
        check("t6_err_pulses", 64'(err_seen), 64'(e0 + 1));
        check("t6_err_cyc", 64'(err_cyc - wr_cyc[base+1]), 64'd9);
        check("t6_port1", 64'(wr_port[base+2]), 64'd1);
        hold[0] = 1'b0;
        drive();
`else
        repeat (20) step();
        check("t6_held_busy", 64'(busy), 64'd1);
        check("t6_held_grant", 64'(grant_id), 64'd0);
        check("t6_no_write", 64'(wr_total), 64'(base + 2));
        check("t6_ready1", 64'(in_ready[1]), 64'd0);
        check("t6_no_err", 64'(err_seen), 64'(e0));
        hold[0] = 1'b0;
        drive();
        wait_writes("t6_wait_b", base + 5, 20);
        check("t6_resume0", 64'(wr_port[base+2]), 64'd0);
        check("t6_last0", 64'(wr_last[base+3]), 64'd1);
        check("t6_port1", 64'(wr_port[base+4]), 64'd1);
`endif
        drain("t6_drain", 100);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
